// File: rtl/sp_fifo_pkg.sv
// Shared constants and types for the single-port-RAM streaming FIFO.
//   WIDTH      : data word width (matches the RAM word)
//   ADDR_W     : RAM address width
//   DEPTH      : RAM words
//   CNT_W      : width of word counters (holds DEPTH + OBUF_DEPTH)
//   OBUF_DEPTH : output buffer entries
package sp_fifo_pkg;
  localparam int unsigned WIDTH      = 18;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DEPTH      = 1 << ADDR_W;
  localparam int unsigned CNT_W      = ADDR_W + 1;
  localparam int unsigned OBUF_DEPTH = 3;
  localparam int unsigned OCC_W      = 2;

  typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/sp_fifo_obuf.sv
// Three-entry shift-register FIFO that absorbs RAM read latency and
// consumer backpressure. Entry 0 is always the head, so head is a flop.
//   push/push_data : capture a word from the RAM
//   pop            : consumer takes the head (only when valid)
//   occ            : entries held
//   valid/head     : registered head-valid flag and head word
module sp_fifo_obuf
  import sp_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  word_t            data_q [OBUF_DEPTH];
  word_t            data_d [OBUF_DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] wr_idx;
  logic             valid_q;

  // Next contents: shift down on pop, then write the new word behind the last survivor.
  always_comb begin
    data_d = data_q;
    occ_d  = occ_q;
    wr_idx = pop ? (occ_q - OCC_W'(1)) : occ_q;
    if (pop) begin
      for (int i = 0; i < OBUF_DEPTH - 1; i++) begin
        data_d[i] = data_q[i+1];
      end
      occ_d = occ_d - OCC_W'(1);
    end
    if (push) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        if (OCC_W'(i) == wr_idx) begin
          data_d[i] = push_data;
        end
      end
      occ_d = occ_d + OCC_W'(1);
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        data_q[i] <= '0;
      end
      occ_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      occ_q   <= occ_d;
      valid_q <= (occ_d != '0);
    end
  end

  assign occ   = occ_q;
  assign valid = valid_q;
  assign head  = data_q[0];

endmodule

// File: rtl/sp_fifo_ctrl_18.sv
// Valid/ready streaming FIFO built on a 1024x18 single-port RAM.
// Writes and reads share the RAM port; a 3-entry output buffer hides the
// one-cycle RAM read latency.
//   wr_valid/wr_ready/wr_data : producer side
//   rd_valid/rd_ready/rd_data : consumer side
//   count                     : words held (RAM + in flight + buffer)
//   ram_we/ram_addr/ram_din   : RAM port controls
//   ram_dout                  : RAM read data, valid the cycle after a read
module sp_fifo_ctrl_18
  import sp_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_din,
  input  logic [WIDTH-1:0]  ram_dout
);

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  ram_cnt_q, count_q;
  logic              inflight_q, wr_prio_q;
  logic [OCC_W-1:0]  occ;
  logic              rd_elig, rd_issue, wr_acc, rd_pop;

  // Arbitration from registered state only; rd_ready and wr_valid never reach wr_ready.
  always_comb begin
    rd_elig  = (ram_cnt_q != '0) &&
               ((3'(occ) + 3'(inflight_q)) < 3'(OBUF_DEPTH));
    rd_issue = rd_elig && !wr_prio_q;
    wr_ready = (ram_cnt_q != CNT_W'(DEPTH)) && !rd_issue;
    wr_acc   = wr_valid && wr_ready;
    rd_pop   = rd_valid && rd_ready;
  end

  // RAM port mux.
  assign ram_we   = wr_acc;
  assign ram_addr = rd_issue ? rd_ptr_q : wr_ptr_q;
  assign ram_din  = wr_data;

  // Pointers, counters and the write-priority flag. Priority is only raised
  // when a write loses to a read, and lasts one cycle: a full RAM must not
  // block the read that drains it, and an idle producer must not stall reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      wr_prio_q  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q  <= wr_ptr_q + ADDR_W'(1);
        ram_cnt_q <= ram_cnt_q + CNT_W'(1);
      end else if (rd_issue) begin
        rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
        ram_cnt_q <= ram_cnt_q - CNT_W'(1);
      end
      inflight_q <= rd_issue;
      wr_prio_q  <= wr_valid && rd_issue;
      count_q    <= count_q + CNT_W'(wr_acc) - CNT_W'(rd_pop);
    end
  end

  assign count = count_q;

  // Output buffer captures the RAM word one cycle after each read.
  sp_fifo_obuf u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (ram_dout),
    .pop       (rd_pop),
    .occ       (occ),
    .valid     (rd_valid),
    .head      (rd_data)
  );

endmodule
